async_fifo_wr_arb: RTL and testbench
====================================

# async_fifo_wr_arb

Round-robin write-port arbiter for the async FIFO, clocked in the write domain. It shares one FIFO write port (data, write enable, full) between NUM_REQ requesters using valid/ready handshakes. Each grant is a burst: it ends on the requester's last beat, at MAX_BURST beats, or after an idle timeout. It sits directly in front of the FIFO write side, so write data and enable are combinational and respect the FIFO full flag in the same cycle.

## Interface
- NUM_REQ, 4: number of requesters (2..8)
- DATAWIDTH, 8: beat width; must match FIFO data width
- MAX_BURST, 4: maximum beats per grant (1..255)
- IDLE_TIMEOUT, 3: consecutive granted cycles with req_valid low before grant release (1..255)
- clk_wr  in  1  write-domain clock
- wrst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_REQ  per-requester beat valid
- req_last  in  NUM_REQ  per-requester end-of-burst marker, qualified by valid
- req_data  in  NUM_REQ*DATAWIDTH  requester i occupies bits [i*DATAWIDTH +: DATAWIDTH]
- req_ready  out  NUM_REQ  per-requester beat accepted this cycle when valid&ready
- fifo_wdata  out  DATAWIDTH  to FIFO write data
- fifo_wren  out  1  to FIFO write enable
- fifo_full  in  1  from FIFO full flag
- grant_id  out  clog2(NUM_REQ)  index of current or most recent grantee
- busy  out  1  high while in state GRANT

## Operation
- Two states: IDLE and GRANT.
- IDLE:
  - If any req_valid is high, select the first valid requester searching from (last_id+1) mod NUM_REQ upward, with wrap-around.
  - Register that index into grant_id and last_id, go to GRANT, and clear beat_cnt and idle_cnt.
  - No requester is ready in IDLE.
- GRANT, requester g = grant_id:
  - req_ready[g] = !fifo_full; all other req_ready bits are 0.
  - fifo_wren = req_valid[g] & !fifo_full.
  - fifo_wdata = req_data slice g. It is a don't-care when fifo_wren is 0; the implementation drives the slice g mux output.
- Transfer: a cycle with fifo_wren=1. Each transfer increments beat_cnt, saturating, width clog2(MAX_BURST+1).
- GRANT -> IDLE when any of these holds:
  - a transfer with req_last[g]=1
  - a transfer that makes beat_cnt equal MAX_BURST
  - idle_cnt reaches IDLE_TIMEOUT
- idle_cnt counts consecutive GRANT cycles with req_valid[g]=0. It clears on any cycle with req_valid[g]=1.
- Cycles with valid high and fifo_full high are stalls: no transfer, no beat count, no idle count.
- last_id is updated only on grant, so round-robin fairness is per burst.
- Reset (async, mid-burst included):
  - state=IDLE, grant_id=0, last_id=NUM_REQ-1 (requester 0 wins first), beat_cnt=0, idle_cnt=0.
  - busy=0, fifo_wren=0, req_ready all 0.
  - An in-flight burst is abandoned; no partial-burst recovery.

## Timing
- Arbitration latency: valid seen in IDLE at cycle N; GRANT and first possible transfer at N+1.
- One IDLE bubble between consecutive bursts. Burst ending at cycle M; next grant decided at M+1; next transfer at M+2 earliest.
- fifo_wren, fifo_wdata and req_ready are combinational from state, grant_id, req_valid and fifo_full. There are no registers between requester and FIFO.
- fifo_full is used in the cycle it is presented; the block adds no write beyond what full permits.
- Simultaneous last and MAX_BURST on the same beat: a single release.
- Timeout and valid returning in the same cycle: valid wins, with no release, because the count clears before compare.
- Dropping valid mid-burst does not release the grant until IDLE_TIMEOUT.

## Test plan
- Single requester 0 sends 3 beats 0x11,0x22,0x33 with last on the 3rd, fifo_full=0. Required: busy rises 1 cycle after valid; fifo_wren high 3 consecutive cycles with those data; busy falls the cycle after 0x33.
- All 4 requesters continuously valid, never last, MAX_BURST=4. Required: grants in order 0,1,2,3,0; exactly 4 beats per grant; 1-cycle bubble between grants.
- Requester 2 in GRANT, fifo_full high for 5 cycles mid-burst. Required: req_ready[2]=0 and fifo_wren=0 for those 5 cycles; beat_cnt unchanged; no timeout; the burst resumes with the next beat in order.
- Requester 1 granted, then drops valid. Required: release after exactly IDLE_TIMEOUT=3 low cycles; grant_id advances to the next valid requester.
- Assert wrst_n=0 mid-burst after 2 beats. Required: fifo_wren, busy and req_ready go 0 immediately. After release, requester 3 alone valid gets its grant 1 cycle later, and a later tie between requesters 0 and 3 resolves to 0 first (last_id reset to 3).
- Last on the MAX_BURST-th beat. Required: exactly one release and no extra bubble.

Source files
------------

// File: rtl/async_fifo_wr_arb_if.sv
`default_nettype none
// ============================================================================
//  Module   : async_fifo_wr_arb_if
//  Purpose  : Bundle of requester-side and FIFO-write-side signals shared by
//             the write-port arbiter and its environment.
//  Ports    : req_valid/req_last/req_data/req_ready - per-requester handshake
//             fifo_wdata/fifo_wren/fifo_full       - FIFO write port
//             grant_id/busy                        - arbiter status
//  Modports : master - requesters + FIFO (drives requests and full flag)
//             slave  - the arbiter
//  Revision : 1.0 - initial release
// ============================================================================
interface async_fifo_wr_arb_if #(
    parameter int NUM_REQ   = 4,
    parameter int DATAWIDTH = 8
);
    localparam int c_GW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_last;
    logic [NUM_REQ*DATAWIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]           req_ready;
    logic [DATAWIDTH-1:0]         fifo_wdata;
    logic                         fifo_wren;
    logic                         fifo_full;
    logic [c_GW-1:0]              grant_id;
    logic                         busy;

    modport master (
        output req_valid, req_last, req_data, fifo_full,
        input  req_ready, fifo_wdata, fifo_wren, grant_id, busy
    );

    modport slave (
        input  req_valid, req_last, req_data, fifo_full,
        output req_ready, fifo_wdata, fifo_wren, grant_id, busy
    );
endinterface
`default_nettype wire

// File: rtl/async_fifo_wr_arb.sv
`default_nettype none
// ============================================================================
//  Module   : async_fifo_wr_arb
//  Purpose  : Round-robin burst arbiter sharing one async-FIFO write port
//             between NUM_REQ valid/ready requesters (write clock domain).
//             A grant ends on last, at MAX_BURST beats, or after
//             IDLE_TIMEOUT consecutive granted cycles without valid.
//  Ports    : clk_wr - write-domain clock
//             wrst_n - asynchronous active-low reset
//             bus    - async_fifo_wr_arb_if.slave (handshakes, FIFO port,
//                      grant_id, busy)
//  Revision : 1.0 - initial release
// ============================================================================
module async_fifo_wr_arb #(
    parameter int NUM_REQ      = 4,
    parameter int DATAWIDTH    = 8,
    parameter int MAX_BURST    = 4,
    parameter int IDLE_TIMEOUT = 3
) (
    input  logic                    clk_wr,
    input  logic                    wrst_n,
    async_fifo_wr_arb_if.slave      bus
);
    localparam int c_GW = $clog2(NUM_REQ);
    localparam int c_BW = $clog2(MAX_BURST + 1);
    localparam int c_IW = $clog2(IDLE_TIMEOUT + 1);

    localparam logic [c_BW-1:0] c_BURST_MAX = c_BW'(MAX_BURST);
    localparam logic [c_IW-1:0] c_IDLE_MAX  = c_IW'(IDLE_TIMEOUT);
    localparam logic [c_GW-1:0] c_LAST_RST  = c_GW'(NUM_REQ - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t              r_state,    w_state_nxt;
    logic [c_GW-1:0]     r_grant_id, w_grant_nxt;
    logic [c_GW-1:0]     r_last_id,  w_last_nxt;
    logic [c_BW-1:0]     r_beat_cnt, w_beat_nxt;
    logic [c_IW-1:0]     r_idle_cnt, w_idle_nxt;
    logic [c_GW-1:0]     w_sel_id;
    logic                w_gvalid;
    logic                w_glast;
    logic                w_xfer;
    logic [NUM_REQ-1:0]  w_ready;
    logic [DATAWIDTH-1:0] w_slice [NUM_REQ];

    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
            assign w_slice[i] = bus.req_data[i*DATAWIDTH +: DATAWIDTH];
        end
    endgenerate

    // Round-robin pick: scan from last_id+NUM_REQ down to last_id+1 so the
    // closest valid requester after last_id is written last and wins.
    always_comb begin
        w_sel_id = r_last_id;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (bus.req_valid[(int'(r_last_id) + k) % NUM_REQ]) begin
                w_sel_id = c_GW'((int'(r_last_id) + k) % NUM_REQ);
            end
        end
    end

    assign w_gvalid = bus.req_valid[r_grant_id];
    assign w_glast  = bus.req_last[r_grant_id];
    assign w_xfer   = (r_state == ST_GRANT) && w_gvalid && !bus.fifo_full;

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant_id;
        w_last_nxt  = r_last_id;
        w_beat_nxt  = r_beat_cnt;
        w_idle_nxt  = r_idle_cnt;
        w_ready     = '0;

        case (r_state)
            ST_IDLE: begin
                if (|bus.req_valid) begin
                    w_state_nxt = ST_GRANT;
                    w_grant_nxt = w_sel_id;
                    w_last_nxt  = w_sel_id;
                    w_beat_nxt  = '0;
                    w_idle_nxt  = '0;
                end
            end
            ST_GRANT: begin
                w_ready[r_grant_id] = !bus.fifo_full;

                // A valid cycle (transfer or stall) clears the idle count
                // before the timeout compare, so returning valid wins.
                if (w_gvalid) begin
                    w_idle_nxt = '0;
                end else if (r_idle_cnt != c_IDLE_MAX) begin
                    w_idle_nxt = r_idle_cnt + c_IW'(1);
                end

                if (w_xfer && (r_beat_cnt != c_BURST_MAX)) begin
                    w_beat_nxt = r_beat_cnt + c_BW'(1);
                end

                // last and MAX_BURST on the same beat collapse to one release
                if ((w_xfer && (w_glast || (w_beat_nxt == c_BURST_MAX))) ||
                    (!w_gvalid && (w_idle_nxt == c_IDLE_MAX))) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_wr or negedge wrst_n) begin
        if (!wrst_n) begin
            r_state    <= ST_IDLE;
            r_grant_id <= '0;
            r_last_id  <= c_LAST_RST;
            r_beat_cnt <= '0;
            r_idle_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant_id <= w_grant_nxt;
            r_last_id  <= w_last_nxt;
            r_beat_cnt <= w_beat_nxt;
            r_idle_cnt <= w_idle_nxt;
        end
    end

    // Write path is purely combinational so the FIFO full flag is honoured
    // in the same cycle it is presented.
    assign bus.req_ready  = w_ready;
    assign bus.fifo_wren  = w_xfer;
    assign bus.fifo_wdata = w_slice[r_grant_id];
    assign bus.grant_id   = r_grant_id;
    assign bus.busy       = (r_state == ST_GRANT);

endmodule
`default_nettype wire

// File: tb/tb_async_fifo_wr_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_async_fifo_wr_arb
//  Purpose  : Directed self-checking bench for async_fifo_wr_arb
//             (NUM_REQ=4, DATAWIDTH=8, MAX_BURST=4, IDLE_TIMEOUT=3).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_async_fifo_wr_arb;
    logic clk_wr = 1'b0;
    logic wrst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk_wr = ~clk_wr;

    async_fifo_wr_arb_if #(.NUM_REQ(4), .DATAWIDTH(8)) bus ();

    async_fifo_wr_arb #(
        .NUM_REQ      (4),
        .DATAWIDTH    (8),
        .MAX_BURST    (4),
        .IDLE_TIMEOUT (3)
    ) dut (
        .clk_wr (clk_wr),
        .wrst_n (wrst_n),
        .bus    (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1 with inputs already set; checks mid-cycle, then
    // advances to the next posedge+1.
    task automatic cyc(input string tag, input logic eb, input logic ew,
                       input logic [3:0] er, input logic [1:0] eg, input logic [7:0] ed);
        #4;
        chk({tag, "_busy"},  32'(bus.busy),      32'(eb));
        chk({tag, "_wren"},  32'(bus.fifo_wren), 32'(ew));
        chk({tag, "_ready"}, 32'(bus.req_ready), 32'(er));
        chk({tag, "_gid"},   32'(bus.grant_id),  32'(eg));
        if (ew) chk({tag, "_wdata"}, 32'(bus.fifo_wdata), 32'(ed));
        @(posedge clk_wr);
        #1;
    endtask

    task automatic do_reset();
        wrst_n = 1'b0;
        @(posedge clk_wr);
        #1;
        chk("rst_busy",  32'(bus.busy),      32'd0);
        chk("rst_wren",  32'(bus.fifo_wren), 32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_gid",   32'(bus.grant_id),  32'd0);
        wrst_n = 1'b1;
    endtask

    task automatic set_d(input int idx, input logic [7:0] d);
        bus.req_data[idx*8 +: 8] = d;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] order [5];
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        bus.fifo_full = 1'b0;
        do_reset();

        // Single requester 0: three beats, last on the third
        bus.req_valid = 4'b0001; set_d(0, 8'h11);
        cyc("t1_idle", 0, 0, 4'b0000, 2'd0, 8'h00);
        cyc("t1_b1",   1, 1, 4'b0001, 2'd0, 8'h11);
        set_d(0, 8'h22);
        cyc("t1_b2",   1, 1, 4'b0001, 2'd0, 8'h22);
        set_d(0, 8'h33); bus.req_last = 4'b0001;
        cyc("t1_b3",   1, 1, 4'b0001, 2'd0, 8'h33);
        bus.req_valid = '0; bus.req_last = '0;
        cyc("t1_rel",  0, 0, 4'b0000, 2'd0, 8'h00);

        // All four continuously valid: 0,1,2,3,0 with 4 beats each and a bubble
        do_reset();
        set_d(0, 8'hA0); set_d(1, 8'hA1); set_d(2, 8'hA2); set_d(3, 8'hA3);
        bus.req_valid = 4'b1111;
        order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd3; order[4] = 2'd0;
        for (int g = 0; g < 5; g++) begin
            cyc("t2_bub", 0, 0, 4'b0000, (g == 0) ? 2'd0 : order[g-1], 8'h00);
            for (int b = 0; b < 4; b++) begin
                cyc("t2_beat", 1, 1, 4'(1 << order[g]), order[g], 8'hA0 + 8'(order[g]));
            end
        end
        bus.req_valid = '0;
        cyc("t2_end", 0, 0, 4'b0000, 2'd0, 8'h00);

        // Requester 2 stalled by fifo_full for 5 cycles mid-burst
        bus.req_valid = 4'b0100; set_d(2, 8'h51);
        cyc("t3_idle", 0, 0, 4'b0000, 2'd0, 8'h00);
        cyc("t3_b1",   1, 1, 4'b0100, 2'd2, 8'h51);
        set_d(2, 8'h52);
        cyc("t3_b2",   1, 1, 4'b0100, 2'd2, 8'h52);
        set_d(2, 8'h53); bus.fifo_full = 1'b1;
        for (int s = 0; s < 5; s++) cyc("t3_stall", 1, 0, 4'b0000, 2'd2, 8'h00);
        bus.fifo_full = 1'b0;
        cyc("t3_b3",   1, 1, 4'b0100, 2'd2, 8'h53);
        set_d(2, 8'h54);
        cyc("t3_b4",   1, 1, 4'b0100, 2'd2, 8'h54);
        bus.req_valid = '0;
        cyc("t3_rel",  0, 0, 4'b0000, 2'd2, 8'h00);

        // Requester 1: valid returns on the would-be timeout cycle, then a real timeout
        bus.req_valid = 4'b0010; set_d(1, 8'h61);
        cyc("t4_idle", 0, 0, 4'b0000, 2'd2, 8'h00);
        cyc("t4_b1",   1, 1, 4'b0010, 2'd1, 8'h61);
        bus.req_valid = 4'b0000;
        cyc("t4_lo",   1, 0, 4'b0010, 2'd1, 8'h00);
        cyc("t4_lo",   1, 0, 4'b0010, 2'd1, 8'h00);
        bus.req_valid = 4'b0010; set_d(1, 8'h62);
        cyc("t4_b2",   1, 1, 4'b0010, 2'd1, 8'h62);
        bus.req_valid = 4'b1000; bus.req_last = 4'b1000; set_d(3, 8'h71);
        for (int s = 0; s < 3; s++) cyc("t4_tmo", 1, 0, 4'b0010, 2'd1, 8'h00);
        cyc("t4_rel",  0, 0, 4'b0000, 2'd1, 8'h00);
        cyc("t4_g3",   1, 1, 4'b1000, 2'd3, 8'h71);
        bus.req_valid = '0; bus.req_last = '0;
        cyc("t4_end",  0, 0, 4'b0000, 2'd3, 8'h00);

        // Asynchronous reset mid-burst after two beats
        bus.req_valid = 4'b0001; set_d(0, 8'h81);
        cyc("t5_idle", 0, 0, 4'b0000, 2'd3, 8'h00);
        cyc("t5_b1",   1, 1, 4'b0001, 2'd0, 8'h81);
        set_d(0, 8'h82);
        cyc("t5_b2",   1, 1, 4'b0001, 2'd0, 8'h82);
        set_d(0, 8'h83);
        #2;
        wrst_n = 1'b0;
        #1;
        chk("t5_arst_busy",  32'(bus.busy),      32'd0);
        chk("t5_arst_wren",  32'(bus.fifo_wren), 32'd0);
        chk("t5_arst_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk_wr);
        #1;
        chk("t5_arst_gid",   32'(bus.grant_id),  32'd0);
        wrst_n = 1'b1;
        bus.req_valid = 4'b1000; bus.req_last = 4'b1000; set_d(3, 8'h91);
        cyc("t5_idle3", 0, 0, 4'b0000, 2'd0, 8'h00);
        cyc("t5_g3",    1, 1, 4'b1000, 2'd3, 8'h91);
        bus.req_valid = 4'b1001; bus.req_last = 4'b1001; set_d(0, 8'hA5);
        cyc("t5_tie",   0, 0, 4'b0000, 2'd3, 8'h00);
        cyc("t5_tie0",  1, 1, 4'b0001, 2'd0, 8'hA5);
        cyc("t5_bub",   0, 0, 4'b0000, 2'd0, 8'h00);
        cyc("t5_tie3",  1, 1, 4'b1000, 2'd3, 8'h91);
        bus.req_valid = '0; bus.req_last = '0;
        cyc("t5_end",   0, 0, 4'b0000, 2'd3, 8'h00);

        // Last on the MAX_BURST-th beat: one release, one bubble, then next grant
        bus.req_valid = 4'b0110; set_d(2, 8'hC1);
        set_d(1, 8'hB1);
        cyc("t6_idle", 0, 0, 4'b0000, 2'd3, 8'h00);
        cyc("t6_b1",   1, 1, 4'b0010, 2'd1, 8'hB1);
        set_d(1, 8'hB2);
        cyc("t6_b2",   1, 1, 4'b0010, 2'd1, 8'hB2);
        set_d(1, 8'hB3);
        cyc("t6_b3",   1, 1, 4'b0010, 2'd1, 8'hB3);
        set_d(1, 8'hB4); bus.req_last = 4'b0010;
        cyc("t6_b4",   1, 1, 4'b0010, 2'd1, 8'hB4);
        bus.req_valid = 4'b0100; bus.req_last = 4'b0100;
        cyc("t6_bub",  0, 0, 4'b0000, 2'd1, 8'h00);
        cyc("t6_g2",   1, 1, 4'b0100, 2'd2, 8'hC1);
        bus.req_valid = '0; bus.req_last = '0;
        cyc("t6_end",  0, 0, 4'b0000, 2'd2, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
